// File: rtl/simple_mmap_axil_intr_slave.sv
// AXI4-Lite slave with an edge-triggered interrupt controller (GIER/IER/ISR/IAR/IPR)
// and two scratch words; single-beat, no buffering, independent read/write channels.
module simple_mmap_axil_intr_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_NUM_INTR         = 1,
    parameter int C_IRQ_ACTIVE_LEVEL = 1
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [C_NUM_INTR-1:0]           intr_in,
    output logic                            irq
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int N  = C_NUM_INTR;

    logic          awready_q, awready_d, bvalid_q, bvalid_d;
    logic          arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d, rd_word;
    logic          gier_q, gier_d;
    logic [N-1:0]  ier_q, ier_d, isr_q, isr_d, intr_prev_q, intr_prev_d;
    logic          armed_q, armed_d, irq_active_q, irq_active_d;
    logic [DW-1:0] scratch0_q, scratch0_d, scratch1_q, scratch1_d;
    logic [DW-1:0] strb_mask;
    logic [N-1:0]  iar_clr, intr_rise;
    logic          wr_fire, rd_fire;
    logic          unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_fire   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire   = arready_q & S_AXI_ARVALID;
    // armed_q masks the first cycle out of reset so a source held high is not seen as an edge
    assign intr_rise = intr_in & ~intr_prev_q & {N{armed_q}};

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = rdata_q;
    assign irq = (C_IRQ_ACTIVE_LEVEL != 0) ? irq_active_q : ~irq_active_q;

    always_comb begin
        rd_word = '0;
        case (S_AXI_ARADDR[4:2])
            3'd0: rd_word[0]   = gier_q;
            3'd1: rd_word[N-1:0] = ier_q;
            3'd2: rd_word[N-1:0] = isr_q;
            3'd4: rd_word[N-1:0] = isr_q & ier_q;
            3'd5: rd_word      = scratch0_q;
            3'd6: rd_word      = scratch1_q;
            default: rd_word   = '0;
        endcase
    end

    always_comb begin
        strb_mask = '0;
        for (int unsigned i = 0; i < DW / 8; i++) begin
            strb_mask[8*i +: 8] = {8{S_AXI_WSTRB[i]}};
        end

        awready_d = ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
        bvalid_d  = bvalid_q;
        if (wr_fire)           bvalid_d = 1'b1;
        else if (S_AXI_BREADY) bvalid_d = 1'b0;

        arready_d = ~arready_q & S_AXI_ARVALID & ~rvalid_q;
        rvalid_d  = rvalid_q;
        if (rd_fire)           rvalid_d = 1'b1;
        else if (S_AXI_RREADY) rvalid_d = 1'b0;
        rdata_d = rd_fire ? rd_word : rdata_q;

        gier_d     = gier_q;
        ier_d      = ier_q;
        scratch0_d = scratch0_q;
        scratch1_d = scratch1_q;
        iar_clr    = '0;
        if (wr_fire) begin
            case (S_AXI_AWADDR[4:2])
                3'd0: gier_d = (gier_q & ~strb_mask[0]) | (S_AXI_WDATA[0] & strb_mask[0]);
                3'd1: ier_d  = (ier_q & ~strb_mask[N-1:0]) | (S_AXI_WDATA[N-1:0] & strb_mask[N-1:0]);
                3'd3: iar_clr = S_AXI_WDATA[N-1:0] & strb_mask[N-1:0];
                3'd5: scratch0_d = (scratch0_q & ~strb_mask) | (S_AXI_WDATA & strb_mask);
                3'd6: scratch1_d = (scratch1_q & ~strb_mask) | (S_AXI_WDATA & strb_mask);
                default: ;
            endcase
        end

        // a new edge wins over a coincident clear
        isr_d        = (isr_q & ~iar_clr) | intr_rise;
        intr_prev_d  = intr_in;
        armed_d      = 1'b1;
        irq_active_d = gier_q & (|(isr_q & ier_q));
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            awready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            gier_q       <= 1'b0;
            ier_q        <= '0;
            isr_q        <= '0;
            intr_prev_q  <= '0;
            armed_q      <= 1'b0;
            irq_active_q <= 1'b0;
            scratch0_q   <= '0;
            scratch1_q   <= '0;
        end else begin
            awready_q    <= awready_d;
            bvalid_q     <= bvalid_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            gier_q       <= gier_d;
            ier_q        <= ier_d;
            isr_q        <= isr_d;
            intr_prev_q  <= intr_prev_d;
            armed_q      <= armed_d;
            irq_active_q <= irq_active_d;
            scratch0_q   <= scratch0_d;
            scratch1_q   <= scratch1_d;
        end
    end

endmodule

// File: tb/tb_simple_mmap_axil_intr_slave.sv
// Self-checking bench: vector table for register access, hand sequences for
// interrupt timing, handshake stalls and reset; read data checked via a scoreboard queue.
module tb_simple_mmap_axil_intr_slave;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [4:0]  S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [0:0]  intr_in;
    logic        irq;

    localparam logic IRQ_ON = 1'b1, IRQ_OFF = 1'b0;

    simple_mmap_axil_intr_slave #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5),
        .C_NUM_INTR(1), .C_IRQ_ACTIVE_LEVEL(1)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .intr_in(intr_in), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    int unsigned passed = 0, total = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Read-data scoreboard: one pop per R-channel handshake
    always @(negedge ACLK) begin
        if (ARESETN && S_AXI_RVALID && S_AXI_RREADY) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'(S_AXI_RVALID), 32'h0);
            end else begin
                check("rdata", S_AXI_RDATA, exp_q.pop_front());
                check("rresp", 32'(S_AXI_RRESP), 32'h0);
            end
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        for (n = 0; n < 50 && !S_AXI_AWREADY; n++) @(negedge ACLK);
        if (n == 50) check("aw_timeout", 32'h1, 32'h0);
        if (S_AXI_AWREADY && !S_AXI_WREADY) check("wready_pair", 32'h0, 32'h1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
        for (n = 0; n < 50 && !S_AXI_BVALID; n++) @(negedge ACLK);
        if (n == 50) check("b_timeout", 32'h1, 32'h0);
        else if (S_AXI_BRESP != 2'b00) check("bresp", 32'(S_AXI_BRESP), 32'h0);
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] exp);
        int n;
        exp_q.push_back(exp);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        for (n = 0; n < 50 && !S_AXI_ARREADY; n++) @(negedge ACLK);
        if (n == 50) check("ar_timeout", 32'h1, 32'h0);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        for (n = 0; n < 50 && !S_AXI_RVALID; n++) @(negedge ACLK);
        if (n == 50) check("r_timeout", 32'h1, 32'h0);
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic pulse_intr();
        @(posedge ACLK); #1 intr_in = 1'b1;
        @(posedge ACLK); #1 intr_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset values, basic RW, strobes, RO/unused words, ignored low address bits
        vecs[0]  = '{1'b0, 5'h00, 32'h0, 4'h0, 32'h0};
        vecs[1]  = '{1'b0, 5'h04, 32'h0, 4'h0, 32'h0};
        vecs[2]  = '{1'b0, 5'h08, 32'h0, 4'h0, 32'h0};
        vecs[3]  = '{1'b0, 5'h14, 32'h0, 4'h0, 32'h0};
        vecs[4]  = '{1'b0, 5'h18, 32'h0, 4'h0, 32'h0};
        vecs[5]  = '{1'b1, 5'h00, 32'h1, 4'hF, 32'h0};
        vecs[6]  = '{1'b1, 5'h04, 32'h2, 4'hF, 32'h0};
        vecs[7]  = '{1'b1, 5'h14, 32'h3, 4'hF, 32'h0};
        vecs[8]  = '{1'b1, 5'h18, 32'h4, 4'hF, 32'h0};
        vecs[9]  = '{1'b0, 5'h00, 32'h0, 4'h0, 32'h1};
        vecs[10] = '{1'b0, 5'h04, 32'h0, 4'h0, 32'h0};
        vecs[11] = '{1'b0, 5'h14, 32'h0, 4'h0, 32'h3};
        vecs[12] = '{1'b0, 5'h18, 32'h0, 4'h0, 32'h4};
        vecs[13] = '{1'b0, 5'h1C, 32'h0, 4'h0, 32'h0};
        vecs[14] = '{1'b0, 5'h0C, 32'h0, 4'h0, 32'h0};
        vecs[15] = '{1'b0, 5'h17, 32'h0, 4'h0, 32'h3};
        vecs[16] = '{1'b1, 5'h14, 32'hAABBCCDD, 4'hF, 32'h0};
        vecs[17] = '{1'b1, 5'h14, 32'h11223344, 4'h5, 32'h0};
        vecs[18] = '{1'b0, 5'h14, 32'h0, 4'h0, 32'hAA22CC44};
        vecs[19] = '{1'b1, 5'h18, 32'hFFFFFFFF, 4'h0, 32'h0};
        vecs[20] = '{1'b0, 5'h18, 32'h0, 4'h0, 32'h4};
        vecs[21] = '{1'b1, 5'h08, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[22] = '{1'b1, 5'h00, 32'hFFFFFFFE, 4'hF, 32'h0};
        vecs[23] = '{1'b0, 5'h00, 32'h0, 4'h0, 32'h0};

        ARESETN = 1'b0; intr_in = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_BREADY = 1'b0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        @(negedge ACLK);
        check("rst_awready", 32'(S_AXI_AWREADY), 32'h0);
        check("rst_bvalid", 32'(S_AXI_BVALID), 32'h0);
        check("rst_rvalid", 32'(S_AXI_RVALID), 32'h0);
        check("rst_irq", 32'(irq), 32'(IRQ_OFF));
        @(posedge ACLK); #1;

        for (int i = 0; i < 24; i++) begin
            if (vecs[i].is_wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            else               axi_read(vecs[i].addr, vecs[i].exp);
        end

        // interrupt latency and IAR clear
        axi_write(5'h00, 32'h1, 4'hF);
        axi_write(5'h04, 32'h1, 4'hF);
        @(posedge ACLK); #1 intr_in = 1'b1;
        @(posedge ACLK); #1 intr_in = 1'b0;
        check("irq_edge_plus1", 32'(irq), 32'(IRQ_OFF));
        @(posedge ACLK); #1;
        check("irq_edge_plus2", 32'(irq), 32'(IRQ_ON));
        axi_read(5'h10, 32'h1);
        axi_read(5'h08, 32'h1);
        axi_write(5'h0C, 32'h1, 4'hF);
        check("irq_after_iar", 32'(irq), 32'(IRQ_OFF));
        axi_read(5'h10, 32'h0);

        // status latches with IER=0; enabling it raises irq
        axi_write(5'h04, 32'h0, 4'hF);
        pulse_intr();
        repeat (3) @(posedge ACLK); #1;
        check("irq_ier0", 32'(irq), 32'(IRQ_OFF));
        axi_read(5'h08, 32'h1);
        axi_read(5'h10, 32'h0);
        axi_write(5'h04, 32'h1, 4'hF);
        check("irq_ier_enable", 32'(irq), 32'(IRQ_ON));
        axi_write(5'h0C, 32'h1, 4'hE);
        axi_read(5'h08, 32'h1);
        axi_write(5'h0C, 32'h1, 4'hF);
        check("irq_cleared", 32'(irq), 32'(IRQ_OFF));

        // IAR clear in the same cycle as a new edge: set wins
        pulse_intr();
        S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        for (n = 0; n < 50 && !S_AXI_AWREADY; n++) @(negedge ACLK);
        if (n == 50) check("aw_timeout_coinc", 32'h1, 32'h0);
        intr_in = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        axi_read(5'h08, 32'h1);
        // a level held high does not re-set after a clear
        axi_write(5'h0C, 32'h1, 4'hF);
        axi_read(5'h08, 32'h0);
        intr_in = 1'b0;

        // stalled channels: AW early, B and R back-pressured
        S_AXI_AWADDR = 5'h18; S_AXI_WDATA = 32'h5A5A1234; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            check("ready_wait_w", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'h0);
        end
        @(posedge ACLK); #1 S_AXI_WVALID = 1'b1;
        for (n = 0; n < 50 && !S_AXI_AWREADY; n++) @(negedge ACLK);
        check("ready_pair", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'h3);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge ACLK);
            check("bvalid_hold", 32'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_BRESP}), 32'h8);
            @(posedge ACLK); #1;
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1 S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        check("bvalid_drop", 32'(S_AXI_BVALID), 32'h0);
        exp_q.push_back(32'h5A5A1234);
        S_AXI_ARADDR = 5'h18; S_AXI_ARVALID = 1'b1;
        for (n = 0; n < 50 && !S_AXI_ARREADY; n++) @(negedge ACLK);
        @(posedge ACLK); #1 S_AXI_ARVALID = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge ACLK);
            check("rvalid_hold", 32'(S_AXI_RVALID), 32'h1);
            check("rdata_hold", S_AXI_RDATA, 32'h5A5A1234);
            check("arready_single", 32'(S_AXI_ARREADY), 32'h0);
            @(posedge ACLK); #1;
        end
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1 S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        check("rvalid_drop", 32'(S_AXI_RVALID), 32'h0);
        @(posedge ACLK); #1;

        // reset during an outstanding write, intr_in held high across release
        axi_write(5'h14, 32'h12345678, 4'hF);
        pulse_intr();
        @(posedge ACLK); #1;
        check("irq_pre_reset", 32'(irq), 32'(IRQ_ON));
        S_AXI_AWADDR = 5'h18; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        for (n = 0; n < 50 && !S_AXI_AWREADY; n++) @(negedge ACLK);
        @(posedge ACLK); #1;
        check("bvalid_pre_reset", 32'(S_AXI_BVALID), 32'h1);
        ARESETN = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; intr_in = 1'b1;
        repeat (2) @(posedge ACLK); #1;
        check("rst_mid_bvalid", 32'(S_AXI_BVALID), 32'h0);
        check("rst_mid_irq", 32'(irq), 32'(IRQ_OFF));
        ARESETN = 1'b1;
        repeat (3) @(posedge ACLK); #1;
        axi_read(5'h00, 32'h0);
        axi_read(5'h04, 32'h0);
        axi_read(5'h08, 32'h0);
        axi_read(5'h14, 32'h0);
        axi_read(5'h18, 32'h0);
        check("irq_post_reset", 32'(irq), 32'(IRQ_OFF));
        intr_in = 1'b0;

        repeat (3) @(posedge ACLK);
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
